pd_tx_serializer: RTL

//  Downstream stage of the hash-separation block: pulls the 16-bit tx_data words it presents and

---
 rtl/pd_tx_serializer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pd_tx_serializer.sv
//=============================================================================
// Module : pd_tx_serializer
// Brief  : Pulls 16-bit words and sends them as one NRZI, bit-stuffed packet
//          on dplus/dminus, closed by an SE0-SE0-J end-of-packet.
// Rev    : 1.0  initial release
//=============================================================================
`default_nettype none

module pd_tx_serializer #(
  parameter int WORD_W     = 16,
  parameter int NUM_WORDS  = 20,
  parameter int BIT_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] tx_data,
  output logic              read_enable,
  output logic              dplus,
  output logic              dminus,
  output logic              transmit_empty,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int c_BIT_W = $clog2(WORD_W);
  localparam int c_WC_W  = $clog2(NUM_WORDS + 1);
  localparam int c_PER_W = $clog2(BIT_PERIOD);
  localparam int c_HALF  = WORD_W / 2;
  localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(WORD_W - 1);
  localparam logic [c_WC_W-1:0]  c_NUM_WORDS = c_WC_W'(NUM_WORDS);
  localparam logic [c_PER_W-1:0] c_PER_MAX   = c_PER_W'(BIT_PERIOD - 1);
  localparam logic [2:0]         c_STUFF_RUN = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SHIFT   = 3'd2,
    S_STUFF   = 3'd3,
    S_EOP_SE0 = 3'd4,
    S_EOP_J   = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_sreg, w_sreg_nxt;
  logic [c_BIT_W-1:0]  r_bit_cnt, w_bit_nxt;
  logic [c_WC_W-1:0]   r_word_cnt, w_word_nxt;
  logic [2:0]          r_ones, w_ones_nxt;
  logic [c_PER_W-1:0]  r_per, w_per_nxt;
  logic                r_dp, w_dp_nxt;
  logic                r_dm, w_dm_nxt;
  logic                r_tail, w_tail_nxt;
  logic                r_done, w_done_nxt;
  logic                w_rd;
  logic [WORD_W-1:0]   w_ord;
  logic [WORD_W-1:0]   w_src;
  logic                w_bnd;
  logic                w_word_end;
  logic                w_more;

  // Reorder so that sending LSB-first yields upper byte first, each byte LSB first
  assign w_ord      = {tx_data[c_HALF-1:0], tx_data[WORD_W-1:c_HALF]};
  assign w_bnd      = (r_per == c_PER_MAX);
  assign w_word_end = (r_bit_cnt == c_LAST_BIT);
  assign w_more     = (r_word_cnt < c_NUM_WORDS);

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_bit_nxt   = r_bit_cnt;
    w_word_nxt  = r_word_cnt;
    w_ones_nxt  = r_ones;
    w_dp_nxt    = r_dp;
    w_dm_nxt    = r_dm;
    w_tail_nxt  = r_tail;
    w_done_nxt  = 1'b0;
    w_rd        = 1'b0;
    w_src       = r_sreg;
    w_per_nxt   = w_bnd ? '0 : r_per + c_PER_W'(1);
    case (r_state)
      S_IDLE: begin
        w_per_nxt = '0;
        w_dp_nxt  = 1'b1;
        w_dm_nxt  = 1'b0;
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_rd        = 1'b1;
        w_word_nxt  = c_WC_W'(1);
        w_bit_nxt   = '0;
        w_tail_nxt  = 1'b0;
        w_per_nxt   = '0;
        w_sreg_nxt  = w_ord >> 1;
        w_ones_nxt  = w_ord[0] ? 3'd1 : 3'd0;
        w_dp_nxt    = w_ord[0] ? r_dp : ~r_dp;
        w_dm_nxt    = ~w_dp_nxt;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: if (w_bnd) begin
        // Next word is fetched on the last data bit even if a stuff bit comes first
        if (w_word_end && w_more) begin
          w_rd       = 1'b1;
          w_word_nxt = r_word_cnt + c_WC_W'(1);
          w_src      = w_ord;
        end
        if (r_ones == c_STUFF_RUN) begin
          w_state_nxt = S_STUFF;
          w_sreg_nxt  = w_src;
          w_ones_nxt  = 3'd0;
          w_dp_nxt    = ~r_dp;
          w_dm_nxt    = r_dp;
          w_tail_nxt  = w_word_end && !w_more;
        end else if (w_word_end && !w_more) begin
          w_state_nxt = S_EOP_SE0;
          w_dp_nxt    = 1'b0;
          w_dm_nxt    = 1'b0;
          w_bit_nxt   = '0;
        end else begin
          w_sreg_nxt = w_src >> 1;
          w_bit_nxt  = r_bit_cnt + c_BIT_W'(1);
          w_ones_nxt = w_src[0] ? r_ones + 3'd1 : 3'd0;
          w_dp_nxt   = w_src[0] ? r_dp : ~r_dp;
          w_dm_nxt   = ~w_dp_nxt;
        end
      end
      S_STUFF: if (w_bnd) begin
        if (r_tail) begin
          w_state_nxt = S_EOP_SE0;
          w_dp_nxt    = 1'b0;
          w_dm_nxt    = 1'b0;
          w_bit_nxt   = '0;
        end else begin
          // bit_cnt wraps to 0 here when the stuff bit sat on a word boundary
          w_state_nxt = S_SHIFT;
          w_sreg_nxt  = r_sreg >> 1;
          w_bit_nxt   = r_bit_cnt + c_BIT_W'(1);
          w_ones_nxt  = r_sreg[0] ? 3'd1 : 3'd0;
          w_dp_nxt    = r_sreg[0] ? r_dp : ~r_dp;
          w_dm_nxt    = ~w_dp_nxt;
        end
      end
      S_EOP_SE0: if (w_bnd) begin
        // bit_cnt counts the two SE0 bit periods
        if (r_bit_cnt == '0) begin
          w_bit_nxt = c_BIT_W'(1);
        end else begin
          w_state_nxt = S_EOP_J;
          w_dp_nxt    = 1'b1;
          w_dm_nxt    = 1'b0;
        end
      end
      S_EOP_J: if (w_bnd) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_ones     <= 3'd0;
      r_per      <= '0;
      r_dp       <= 1'b1;
      r_dm       <= 1'b0;
      r_tail     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_sreg     <= w_sreg_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_word_cnt <= w_word_nxt;
      r_ones     <= w_ones_nxt;
      r_per      <= w_per_nxt;
      r_dp       <= w_dp_nxt;
      r_dm       <= w_dm_nxt;
      r_tail     <= w_tail_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign read_enable    = w_rd & ~rst;
  assign dplus          = r_dp;
  assign dminus         = r_dm;
  assign transmit_empty = (r_state == S_IDLE);
  assign tx_busy        = (r_state != S_IDLE);
  assign tx_done        = r_done;

endmodule

`default_nettype wire
